// File: rtl/axis_lfsr_checker_pkg.sv
// Shared constants, checker state type and small helpers for the LFSR stream checker.
package axis_lfsr_checker_pkg;

  localparam int unsigned DEF_TDATAW       = 32;
  localparam int unsigned DEF_TDESTW       = 4;
  localparam int unsigned DEF_LFSR_DW      = 32;
  localparam logic [31:0] DEF_LFSR_DEFAULT = 32'hACE1_0001;
  localparam int unsigned DEF_PKT_LEN      = 4;
  localparam int unsigned DEF_CNTW         = 16;
  localparam int unsigned MASKW            = 16;

  // Galois right-shift taps, x^32 + x^22 + x^2 + x + 1; must match the generator.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } checker_state_t;

  // An all-zero backpressure mask would stall forever, so it means "always ready".
  function automatic logic [MASKW-1:0] eff_mask(input logic [MASKW-1:0] m);
    return (m == '0) ? '1 : m;
  endfunction

endpackage

// File: rtl/axis_lfsr_checker_lfsr_next.sv
// One combinational step of the Galois LFSR shared with the stream generator.
module lfsr_next #(
  parameter int unsigned W    = 32,
  parameter logic [W-1:0] TAPS = '1
) (
  input  logic [W-1:0] cur,
  output logic [W-1:0] nxt_c
);

  // Shift right; fold taps back in when the bit shifted out is 1.
  always_comb begin
    nxt_c = cur >> 1;
    if (cur[0]) nxt_c = nxt_c ^ TAPS;
  end

endmodule

// File: rtl/axis_lfsr_checker.sv
// AXI-Stream sink that checks an LFSR payload, TDEST and packet framing,
// with a rotating backpressure pattern on TREADY and saturating counters.
module axis_lfsr_checker
  import axis_lfsr_checker_pkg::*;
#(
  parameter int unsigned  TDATAW       = DEF_TDATAW,
  parameter int unsigned  TDESTW       = DEF_TDESTW,
  parameter int unsigned  LFSR_DW      = DEF_LFSR_DW,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = LFSR_DW'(DEF_LFSR_DEFAULT),
  parameter logic [TDESTW-1:0]  MY_ADDR      = '0,
  parameter int unsigned  PKT_LEN      = DEF_PKT_LEN,
  parameter int unsigned  CNTW         = DEF_CNTW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENABLE,
  input  logic              CLEAR,
  input  logic [CNTW-1:0]   NUM_PKTS,
  input  logic [15:0]       READY_MASK,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic [CNTW-1:0]   BEAT_CNT,
  output logic [CNTW-1:0]   PKT_CNT,
  output logic [CNTW-1:0]   ERR_CNT,
  output logic              ERR,
  output logic [TDATAW-1:0] FIRST_ERR_DATA,
  output logic              DONE
);

  localparam int unsigned     IDXW     = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(PKT_LEN - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  checker_state_t     state;
  checker_state_t     state_nxt_c;
  logic [MASKW-1:0]   pattern;
  logic [MASKW-1:0]   pattern_nxt_c;
  logic [LFSR_DW-1:0] lfsr;
  logic [LFSR_DW-1:0] lfsr_adv_c;
  logic [IDXW-1:0]    beat_idx;

  logic               accept_c;
  logic               idx_last_c;
  logic               beat_err_c;
  logic [CNTW-1:0]    beat_cnt_inc_c;
  logic [CNTW-1:0]    pkt_cnt_inc_c;
  logic [CNTW-1:0]    err_cnt_inc_c;

  lfsr_next #(
    .W    (LFSR_DW),
    .TAPS (LFSR_DW'(LFSR_TAPS))
  ) u_lfsr_next (
    .cur   (lfsr),
    .nxt_c (lfsr_adv_c)
  );

  // Beat acceptance, per-beat checks, saturating increments and next state.
  always_comb begin
    accept_c       = AXIS_S_TVALID & AXIS_S_TREADY & (state == ST_RECV);
    idx_last_c     = (beat_idx == LAST_IDX);
    beat_err_c     = (AXIS_S_TDATA[LFSR_DW-1:0] != lfsr)
                   | (AXIS_S_TDEST != MY_ADDR)
                   | (AXIS_S_TLAST != idx_last_c);
    beat_cnt_inc_c = (BEAT_CNT == CNT_MAX) ? BEAT_CNT : BEAT_CNT + CNTW'(1);
    pkt_cnt_inc_c  = (PKT_CNT  == CNT_MAX) ? PKT_CNT  : PKT_CNT  + CNTW'(1);
    err_cnt_inc_c  = (ERR_CNT  == CNT_MAX) ? ERR_CNT  : ERR_CNT  + CNTW'(1);

    pattern_nxt_c = pattern;
    if (state == ST_RECV) pattern_nxt_c = {pattern[0], pattern[MASKW-1:1]};

    state_nxt_c = state;
    case (state)
      ST_IDLE: if (ENABLE) state_nxt_c = ST_RECV;
      ST_RECV: if (accept_c && AXIS_S_TLAST && (NUM_PKTS != '0) &&
                   (pkt_cnt_inc_c == NUM_PKTS)) state_nxt_c = ST_DONE;
      ST_DONE: state_nxt_c = ST_DONE;
      default: state_nxt_c = ST_IDLE;
    endcase
    if (CLEAR) state_nxt_c = ST_IDLE;
  end

  // FSM, pattern rotator, LFSR, beat index, counters and error capture.
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      state          <= ST_IDLE;
      pattern        <= eff_mask(READY_MASK);
      AXIS_S_TREADY  <= 1'b0;
      lfsr           <= LFSR_DEFAULT;
      beat_idx       <= '0;
      BEAT_CNT       <= '0;
      PKT_CNT        <= '0;
      ERR_CNT        <= '0;
      ERR            <= 1'b0;
      FIRST_ERR_DATA <= '0;
      DONE           <= 1'b0;
    end else begin
      state         <= state_nxt_c;
      pattern       <= pattern_nxt_c;
      AXIS_S_TREADY <= (state_nxt_c == ST_RECV) & pattern_nxt_c[0];
      DONE          <= (state_nxt_c == ST_DONE);
      if (accept_c) begin
        // Data errors never resync: the LFSR always advances one step per beat.
        lfsr     <= lfsr_adv_c;
        beat_idx <= (AXIS_S_TLAST || idx_last_c) ? '0 : beat_idx + IDXW'(1);
        BEAT_CNT <= beat_cnt_inc_c;
        if (AXIS_S_TLAST) PKT_CNT <= pkt_cnt_inc_c;
        if (beat_err_c) begin
          ERR_CNT <= err_cnt_inc_c;
          ERR     <= 1'b1;
          if (!ERR) FIRST_ERR_DATA <= AXIS_S_TDATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Directed bench for axis_lfsr_checker (CNTW=4, MY_ADDR=3, PKT_LEN=4).
module tb_axis_lfsr_checker;

  localparam logic [31:0] SEED = 32'hACE1_0001;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [3:0]  ADDR = 4'd3;

  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic [3:0]  num_pkts;
  logic [15:0] ready_mask;
  logic        tvalid, tready, tlast;
  logic [31:0] tdata;
  logic [3:0]  tdest;
  logic [3:0]  beat_cnt, pkt_cnt, err_cnt;
  logic        err, done;
  logic [31:0] first_err_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] seq [0:31];

  axis_lfsr_checker #(
    .TDATAW(32), .TDESTW(4), .LFSR_DW(32), .LFSR_DEFAULT(SEED),
    .MY_ADDR(ADDR), .PKT_LEN(4), .CNTW(4)
  ) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .CLEAR(clear),
    .NUM_PKTS(num_pkts), .READY_MASK(ready_mask),
    .AXIS_S_TVALID(tvalid), .AXIS_S_TREADY(tready),
    .AXIS_S_TDATA(tdata), .AXIS_S_TLAST(tlast), .AXIS_S_TDEST(tdest),
    .BEAT_CNT(beat_cnt), .PKT_CNT(pkt_cnt), .ERR_CNT(err_cnt),
    .ERR(err), .FIRST_ERR_DATA(first_err_data), .DONE(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ TAPS;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat, wait (bounded) for TREADY, then let it be accepted.
  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] dst);
    int n;
    n = 0;
    tvalid = 1'b1; tdata = d; tlast = l; tdest = dst;
    while (!tready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    tick();
    tvalid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    seq[0] = SEED;
    for (int i = 1; i < 32; i++) seq[i] = step(seq[i-1]);

    rst = 1'b1; enable = 1'b0; clear = 1'b0; num_pkts = 4'd2; ready_mask = 16'hFFFF;
    tvalid = 1'b0; tdata = '0; tlast = 1'b0; tdest = ADDR;
    tick(); tick();

    // Reset state
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_beat",   32'(beat_cnt), 32'd0);
    chk("rst_pkt",    32'(pkt_cnt), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_first",  first_err_data, 32'd0);
    chk("rst_done",   32'(done), 32'd0);

    // Two clean packets, NUM_PKTS=2 -> DONE
    rst = 1'b0; enable = 1'b1;
    tick();
    chk("t1_ready", 32'(tready), 32'd1);
    for (int k = 0; k < 8; k++) send(seq[k], (k % 4) == 3, ADDR);
    chk("t1_beat",   32'(beat_cnt), 32'd8);
    chk("t1_pkt",    32'(pkt_cnt), 32'd2);
    chk("t1_err",    32'(err), 32'd0);
    chk("t1_done",   32'(done), 32'd1);
    chk("t1_tready", 32'(tready), 32'd0);
    tvalid = 1'b1; tdata = seq[8]; tlast = 1'b0;
    tick(); tick(); tick();
    tvalid = 1'b0;
    chk("t1_beat_hold", 32'(beat_cnt), 32'd8);
    chk("t1_done_hold", 32'(done), 32'd1);

    // Beat 3 data bit0 flipped
    num_pkts = 4'd0;
    pulse_clear();
    chk("t2_clr_done", 32'(done), 32'd0);
    tick();
    for (int k = 0; k < 8; k++)
      send((k == 2) ? (seq[k] ^ 32'd1) : seq[k], (k % 4) == 3, ADDR);
    chk("t2_errcnt", 32'(err_cnt), 32'd1);
    chk("t2_err",    32'(err), 32'd1);
    chk("t2_first",  first_err_data, seq[2] ^ 32'd1);
    chk("t2_beat",   32'(beat_cnt), 32'd8);

    // Bad TDEST on beat 1; early TLAST on beat 2 resyncs the index
    pulse_clear();
    tick();
    send(seq[0], 1'b0, ADDR + 4'd1);
    send(seq[1], 1'b0, ADDR);
    send(seq[2], 1'b0, ADDR);
    send(seq[3], 1'b1, ADDR);
    chk("t3_dest_errcnt", 32'(err_cnt), 32'd1);
    chk("t3_first",       first_err_data, seq[0]);
    send(seq[4], 1'b0, ADDR);
    send(seq[5], 1'b1, ADDR);
    chk("t3_last_errcnt", 32'(err_cnt), 32'd2);
    for (int k = 6; k < 10; k++) send(seq[k], k == 9, ADDR);
    chk("t3_resync_errcnt", 32'(err_cnt), 32'd2);
    chk("t3_pkt",           32'(pkt_cnt), 32'd3);
    chk("t3_beat",          32'(beat_cnt), 32'd10);

    // Backpressure 5555 with TVALID held and data stable while stalled
    ready_mask = 16'h5555;
    pulse_clear();
    begin
      int k;
      k = 0;
      tvalid = 1'b1; tdata = seq[0]; tlast = 1'b0; tdest = ADDR;
      tick();
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("t4_ready_%0d", i), 32'(tready), 32'((i % 2) == 0));
        if (tready) begin
          tick();
          k++;
          tdata = seq[k]; tlast = (k == 3);
        end else begin
          tick();
        end
      end
      tvalid = 1'b0;
    end
    chk("t4_beat",   32'(beat_cnt), 32'd4);
    chk("t4_pkt",    32'(pkt_cnt), 32'd1);
    chk("t4_errcnt", 32'(err_cnt), 32'd0);

    // CLEAR in the same cycle as an accepted beat
    ready_mask = 16'hFFFF;
    pulse_clear();
    tick();
    send(seq[0], 1'b0, ADDR);
    enable = 1'b0;
    tvalid = 1'b1; tdata = seq[1]; tlast = 1'b0; tdest = ADDR;
    chk("t5_ready_pre", 32'(tready), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0; tvalid = 1'b0;
    chk("t5_beat",   32'(beat_cnt), 32'd0);
    chk("t5_pkt",    32'(pkt_cnt), 32'd0);
    chk("t5_errcnt", 32'(err_cnt), 32'd0);
    chk("t5_tready", 32'(tready), 32'd0);
    tick(); tick();
    chk("t5_idle_tready", 32'(tready), 32'd0);
    enable = 1'b1;
    tick();
    send(seq[0], 1'b0, ADDR);
    chk("t5_reseed_errcnt", 32'(err_cnt), 32'd0);
    chk("t5_reseed_beat",   32'(beat_cnt), 32'd1);

    // 20 single-beat packets, NUM_PKTS=0: counters saturate, no DONE
    pulse_clear();
    tick();
    for (int k = 0; k < 20; k++) send(seq[k], 1'b1, ADDR);
    chk("t6_pkt",    32'(pkt_cnt), 32'd15);
    chk("t6_beat",   32'(beat_cnt), 32'd15);
    chk("t6_errcnt", 32'(err_cnt), 32'd15);
    chk("t6_err",    32'(err), 32'd1);
    chk("t6_done",   32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
